z80_mmu_loader: RTL
===================

# z80_mmu_loader

Bus-master sequencer that programs the Z80 MMU page table. On `start` it fetches `count` page-frame bytes from a source memory through a req/ack handshake and issues one Z80-style write cycle per entry to the MMU table-write window (`{TABLE_PAGE, entry}`). It sits between the boot ROM/config store and the MMU's virtual address/data inputs, and is arbitrated onto that bus only while `busy` is high.

## Interface
- `TABLE_PAGE`, 8'h00: upper address byte that selects the MMU table-write window.
- `WR_CYCLES`, 2: number of cycles `mmu_wr_n` is held low per write, range 1..15.
- `clk`  in  1  the single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request; ignored while `busy`.
- `first`  in  8  first page-table index; sampled with `start`.
- `count`  in  9  number of entries, 0..256; sampled with `start`.
- `abort`  in  1  level; stops the sequence at the next safe point.
- `busy`  out  1  high from the cycle after the accepted `start` until completion or abort.
- `done`  out  1  one-cycle pulse on normal completion only.
- `src_req`  out  1  fetch request; held until acknowledged.
- `src_addr`  out  8  source index k (0..count-1); stable while `src_req` is high.
- `src_ack`  in  1  source acknowledge; `src_data` is valid in the same cycle.
- `src_data`  in  8  physical page-frame byte.
- `mmu_addr`  out  16  `{TABLE_PAGE, (first+k) mod 256}`.
- `mmu_data`  out  8  captured `src_data`.
- `mmu_wr_n`  out  1  active-low write strobe.

## Operation
- States: IDLE, FETCH, SETUP, STROBE, HOLD, DONE.
- IDLE: if `start` is high and `count` != 0, latch `first` and `count`, set k=0, and go to FETCH. If `start` is high and `count` == 0, go to DONE. No write cycles occur for `count` == 0.
- FETCH: `src_req` = 1 and `src_addr` = k. On the edge where `src_req` and `src_ack` are both high, capture `src_data` into `mmu_data`, load `mmu_addr`, and go to SETUP.
- SETUP: address and data are driven with `mmu_wr_n` = 1 for exactly 1 cycle, then go to STROBE.
- STROBE: `mmu_wr_n` = 0 for exactly `WR_CYCLES` cycles, timed by a 4-bit down-counter, then go to HOLD.
- HOLD: `mmu_wr_n` = 1 and address/data are held for 1 cycle. Then increment k. If k == latched count, go to DONE; otherwise go to FETCH.
- DONE: `done` = 1 for one cycle, `busy` = 0, then return to IDLE.
- Entry index arithmetic is 8-bit and wraps: first=8'hFF, k=1 gives entry 8'h00.
- `count` = 256 writes all 256 entries. k and the remaining count are 9-bit.
- `abort`:
  - In FETCH, drop `src_req` and go to IDLE.
  - In SETUP, go to IDLE without strobing.
  - In STROBE, finish the strobe and HOLD, then go to IDLE.
  - `done` is never pulsed after an abort.
- An `abort` that coincides with `start` in IDLE wins: the sequence is not started.
- `start` asserted while `busy` has no effect.
- Reset values (also applied on reset mid-operation): state IDLE, `busy` 0, `done` 0, `src_req` 0, `src_addr` 0, `mmu_addr` 0, `mmu_data` 0, `mmu_wr_n` 1. A reset during STROBE releases `mmu_wr_n` immediately (asynchronous).

## Timing
- All outputs are registered.
- `start` sampled at edge T: `busy` = 1 and `src_req` = 1 from T+1.
- Per entry: FETCH (≥1 cycle, ack-dependent) + 1 + `WR_CYCLES` + 1. With ack in the first FETCH cycle and `WR_CYCLES` = 2, this is 5 cycles per entry.
- `mmu_addr` and `mmu_data` are stable from SETUP through HOLD, covering ≥1 cycle before and ≥1 cycle after the strobe.
- The last HOLD is followed by DONE. `done` rises and `busy` falls on the same edge.
- `src_req` drops the edge after the ack.

## Structure
- Package `z80_mmu_pkg` holds:
  - the state enum;
  - the `TABLE_PAGE` default;
  - a function `tbl_addr(first, k)` returning the 16-bit window address.
- No sub-module. A single module with the FSM, the k counter, and the strobe counter.

## Test plan
- first=8'h10, count=3, immediate ack, src_data=A1,A2,A3 → writes {00,10}=A1, {00,11}=A2, {00,12}=A3; `mmu_wr_n` low for 2 cycles each; `done` at cycle 16 after `start`.
- first=8'hFE, count=4 → entries FE, FF, 00, 01 in order; `done` pulses once.
- count=0 → no `src_req`, no strobe; `done` pulses one cycle after `start`.
- Ack delayed 3 cycles → `src_req` and `src_addr` held for 3 cycles; no strobe until the data is captured.
- `abort` during the second STROBE → the strobe completes at full width, `busy` drops after HOLD, `done` stays 0. `abort` during FETCH → `src_req` drops next cycle.
- `rst_n` pulled low mid-STROBE → `mmu_wr_n` is 1 immediately, all outputs return to reset values, and a new `start` after release works normally.

Source files
------------

// File: rtl/z80_mmu_pkg.sv
// Shared types and helpers for the Z80 MMU page-table loader.
package z80_mmu_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSetup,
    StStrobe,
    StHold,
    StDone
  } state_e;

  // Upper address byte selecting the MMU table-write window.
  localparam logic [7:0] TABLE_PAGE_DEFAULT = 8'h00;

  // Window address for entry (first + k); the entry index wraps at 8 bits.
  function automatic logic [15:0] tbl_addr(input logic [7:0] first,
                                           input logic [8:0] k,
                                           input logic [7:0] page = TABLE_PAGE_DEFAULT);
    logic [7:0] entry;
    entry = first + k[7:0];
    return {page, entry};
  endfunction

endpackage

// File: rtl/z80_mmu_loader_if.sv
// Control, source-fetch and MMU write-bus signals of the page-table loader.
interface z80_mmu_loader_if;

  logic        start;
  logic [7:0]  first;
  logic [8:0]  count;
  logic        abort;
  logic        busy;
  logic        done;
  logic        src_req;
  logic [7:0]  src_addr;
  logic        src_ack;
  logic [7:0]  src_data;
  logic [15:0] mmu_addr;
  logic [7:0]  mmu_data;
  logic        mmu_wr_n;

  // The loader is the bus master.
  modport master (
    input  start, first, count, abort, src_ack, src_data,
    output busy, done, src_req, src_addr, mmu_addr, mmu_data, mmu_wr_n
  );

  // Controller, source memory and MMU side.
  modport slave (
    output start, first, count, abort, src_ack, src_data,
    input  busy, done, src_req, src_addr, mmu_addr, mmu_data, mmu_wr_n
  );

endinterface

// File: rtl/z80_mmu_loader.sv
// Fetches page-frame bytes from a source memory and writes them into the MMU
// page table, one Z80-style write cycle per entry. All outputs are registered.
module z80_mmu_loader
  import z80_mmu_pkg::*;
#(
  parameter logic [7:0]  TABLE_PAGE = TABLE_PAGE_DEFAULT,
  parameter int unsigned WR_CYCLES  = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  z80_mmu_loader_if.master bus_io
);

  // Strobe counter counts WR_CYCLES-1 down to 0 while the strobe is low.
  localparam logic [3:0] StrbLoad = 4'(WR_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  first_q;
  logic [8:0]  count_q;
  logic [8:0]  k_q;
  logic [3:0]  strb_cnt_q;
  logic        abort_q;
  logic        busy_q;
  logic        done_q;
  logic        src_req_q;
  logic [7:0]  src_addr_q;
  logic [15:0] mmu_addr_q;
  logic [7:0]  mmu_data_q;
  logic        mmu_wr_n_q;

  logic [8:0]  k_inc;

  assign k_inc = k_q + 9'd1;

  // Sequencer: state, entry counter, strobe timer and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      first_q    <= 8'h00;
      count_q    <= 9'd0;
      k_q        <= 9'd0;
      strb_cnt_q <= 4'd0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_req_q  <= 1'b0;
      src_addr_q <= 8'h00;
      mmu_addr_q <= 16'h0000;
      mmu_data_q <= 8'h00;
      mmu_wr_n_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          // An abort in the same cycle as start keeps the loader idle.
          if (bus_io.start && !bus_io.abort) begin
            if (bus_io.count == 9'd0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              first_q    <= bus_io.first;
              count_q    <= bus_io.count;
              k_q        <= 9'd0;
              src_addr_q <= 8'h00;
              src_req_q  <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= StFetch;
            end
          end
        end

        StFetch: begin
          if (bus_io.abort) begin
            src_req_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end else if (bus_io.src_ack) begin
            mmu_data_q <= bus_io.src_data;
            mmu_addr_q <= tbl_addr(first_q, k_q, TABLE_PAGE);
            src_req_q  <= 1'b0;
            state_q    <= StSetup;
          end
        end

        StSetup: begin
          if (bus_io.abort) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            mmu_wr_n_q <= 1'b0;
            strb_cnt_q <= StrbLoad;
            state_q    <= StStrobe;
          end
        end

        StStrobe: begin
          // A strobe in progress always completes; remember the abort for HOLD.
          if (bus_io.abort) begin
            abort_q <= 1'b1;
          end
          if (strb_cnt_q == 4'd0) begin
            mmu_wr_n_q <= 1'b1;
            state_q    <= StHold;
          end else begin
            strb_cnt_q <= strb_cnt_q - 4'd1;
          end
        end

        StHold: begin
          k_q <= k_inc;
          if (abort_q || bus_io.abort) begin
            abort_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (k_inc == count_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            src_addr_q <= k_inc[7:0];
            src_req_q  <= 1'b1;
            state_q    <= StFetch;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
  assign bus_io.src_req  = src_req_q;
  assign bus_io.src_addr = src_addr_q;
  assign bus_io.mmu_addr = mmu_addr_q;
  assign bus_io.mmu_data = mmu_data_q;
  assign bus_io.mmu_wr_n = mmu_wr_n_q;

endmodule
